// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame parser states, error codes
// and default line parameters.
package uart_pkg;

  localparam int         CLKS_PER_BIT      = 868;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_DRAIN   = 3'd5
  } frame_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_LEN     = 2'b01;
  localparam logic [1:0] ERR_CHK     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: MAX_LEN bytes, one synchronous write port and one
// combinational read port. Contents are not reset.
module uart_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [MAX_LEN];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser behind uart_rx: SYNC, ADDR, LEN, PAYLOAD[LEN], CHK. The payload is
// buffered and written to the register file only after the XOR checksum matches.
module uart_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 86800
) (
  input  logic       i_Clock,
  input  logic       i_nRst,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  input  logic       i_Wr_Ready,
  output logic       o_Wr_Valid,
  output logic [7:0] o_Wr_Addr,
  output logic [7:0] o_Wr_Data,
  output logic       o_Busy,
  output logic       o_Frame_Done,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TO_W   = $clog2(TIMEOUT_CLKS);
  // The counter takes the value TIMEOUT_CLKS-1 on the edge where it would pass
  // TO_LAST, so the abort is taken on that edge instead of one later.
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CLKS - 2);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  logic [1:0]        rst_sync_q;
  logic              rst_n;

  frame_state_e      state_q, state_d;
  logic [7:0]        base_q, base_d;
  logic [IDX_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        chk_q, chk_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              wr_valid_q, wr_valid_d;
  logic [7:0]        wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              buf_we;
  logic [BUF_AW-1:0] rd_idx;
  logic [7:0]        rd_data;

  // Reset asserts immediately, releases two edges later in this clock domain.
  always_ff @(posedge i_Clock or negedge i_nRst) begin
    if (!i_nRst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (BUF_AW)
  ) u_buf (
    .clk_i   (i_Clock),
    .we_i    (buf_we),
    .waddr_i (idx_q[BUF_AW-1:0]),
    .wdata_i (i_Rx_Byte),
    .raddr_i (rd_idx),
    .rdata_o (rd_data)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    to_cnt_d   = '0;
    wr_valid_d = wr_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    buf_we     = 1'b0;
    rd_idx     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (i_Rx_DV) begin
          base_d  = i_Rx_Byte;
          chk_d   = i_Rx_Byte;
          state_d = ST_LEN;
        end
      end

      ST_LEN: begin
        if (i_Rx_DV) begin
          chk_d = chk_q ^ i_Rx_Byte;
          len_d = i_Rx_Byte[IDX_W-1:0];
          idx_d = '0;
          if (i_Rx_Byte > MAX_LEN_B) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else if (i_Rx_Byte == 8'd0) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (i_Rx_DV) begin
          buf_we = 1'b1;
          chk_d  = chk_q ^ i_Rx_Byte;
          idx_d  = idx_q + IDX_W'(1);
          if (idx_q == len_q - IDX_W'(1)) begin
            state_d = ST_CHK;
          end
        end
      end

      ST_CHK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte != chk_q) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
            state_d    = ST_IDLE;
          end else if (len_q == '0) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // rd_idx defaults to 0, so the first payload byte is loaded here.
            idx_d      = '0;
            wr_valid_d = 1'b1;
            wr_addr_d  = base_q;
            wr_data_d  = rd_data;
            state_d    = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        rd_idx = idx_q[BUF_AW-1:0] + BUF_AW'(1);
        if (wr_valid_q && i_Wr_Ready) begin
          if (idx_q == len_q - IDX_W'(1)) begin
            wr_valid_d = 1'b0;
            done_d     = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            wr_addr_d = wr_addr_q + 8'd1;
            wr_data_d = rd_data;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Inter-byte timeout; a DV on the limit cycle takes precedence.
    if ((state_q inside {ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CHK}) && !i_Rx_DV) begin
      if (to_cnt_q == TO_LAST) begin
        err_d      = 1'b1;
        err_code_d = ERR_TIMEOUT;
        state_d    = ST_IDLE;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge i_Clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      chk_q      <= '0;
      to_cnt_q   <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      to_cnt_q   <= to_cnt_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign o_Wr_Valid   = wr_valid_q;
  assign o_Wr_Addr    = wr_addr_q;
  assign o_Wr_Data    = wr_data_q;
  assign o_Busy       = (state_q != ST_IDLE);
  assign o_Frame_Done = done_q;
  assign o_Frame_Err  = err_q;
  assign o_Err_Code   = err_code_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl: byte-level frame model with a per-cycle compare
// process, plus directed frames with literal expectations.
module tb_uart_frame_ctrl;
  import uart_pkg::*;

  localparam int T    = 40;
  localparam int MAXL = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] rxb = 8'h00;
  logic       rdy = 1'b1;
  logic       o_Wr_Valid, o_Busy, o_Frame_Done, o_Frame_Err;
  logic [7:0] o_Wr_Addr, o_Wr_Data;
  logic [1:0] o_Err_Code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_frame_ctrl #(
    .SYNC_BYTE    (8'hA5),
    .MAX_LEN      (MAXL),
    .TIMEOUT_CLKS (T)
  ) dut (
    .i_Clock      (clk),
    .i_nRst       (rst_n),
    .i_Rx_DV      (dv),
    .i_Rx_Byte    (rxb),
    .i_Wr_Ready   (rdy),
    .o_Wr_Valid   (o_Wr_Valid),
    .o_Wr_Addr    (o_Wr_Addr),
    .o_Wr_Data    (o_Wr_Data),
    .o_Busy       (o_Busy),
    .o_Frame_Done (o_Frame_Done),
    .o_Frame_Err  (o_Frame_Err),
    .o_Err_Code   (o_Err_Code)
  );

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
    end
  endfunction

  // Frame model: collects bytes after SYNC and decides the outcome once the
  // frame is complete, from length and XOR rules only.
  logic [7:0] exp_wa[$];
  logic [7:0] exp_wd[$];
  logic [1:0] exp_err[$];
  int         exp_done = 0;
  logic [1:0] exp_code = 2'b00;
  logic       in_frame = 1'b0;
  logic [7:0] fr[$];
  logic       started = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_a = 8'h00, prev_d = 8'h00;
  logic [7:0] frm[$];

  function automatic void model_byte(input logic [7:0] b);
    logic [7:0] x;
    int n;
    if (exp_wa.size() != 0) return;
    if (!in_frame) begin
      if (b == 8'hA5) begin
        in_frame = 1'b1;
        fr.delete();
      end
      return;
    end
    fr.push_back(b);
    n = fr.size();
    if (n == 2 && fr[1] > 8'(MAXL)) begin
      exp_err.push_back(ERR_LEN);
      in_frame = 1'b0;
    end else if (n >= 2 && n == int'(fr[1]) + 3) begin
      x = 8'h00;
      for (int i = 0; i < n - 1; i++) x = x ^ fr[i];
      if (x != fr[n-1]) begin
        exp_err.push_back(ERR_CHK);
      end else begin
        for (int i = 0; i < int'(fr[1]); i++) begin
          exp_wa.push_back(fr[0] + 8'(i));
          exp_wd.push_back(fr[2+i]);
        end
        exp_done++;
      end
      in_frame = 1'b0;
    end
  endfunction

  function automatic void model_timeout();
    exp_err.push_back(ERR_TIMEOUT);
    in_frame = 1'b0;
  endfunction

  function automatic void model_reset();
    exp_wa.delete();
    exp_wd.delete();
    exp_err.delete();
    exp_done   = 0;
    exp_code   = ERR_NONE;
    in_frame   = 1'b0;
    prev_stall = 1'b0;
  endfunction

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (started && rst_n) begin
      if (prev_stall) begin
        check("hold_valid", o_Wr_Valid, 1);
        check("hold_addr", o_Wr_Addr, prev_a);
        check("hold_data", o_Wr_Data, prev_d);
      end
      prev_stall = o_Wr_Valid && !rdy;
      prev_a     = o_Wr_Addr;
      prev_d     = o_Wr_Data;
      if (o_Wr_Valid && rdy) begin
        check("wr_expected", exp_wa.size() != 0, 1);
        if (exp_wa.size() != 0) begin
          check("wr_addr", o_Wr_Addr, exp_wa.pop_front());
          check("wr_data", o_Wr_Data, exp_wd.pop_front());
        end
      end
      if (o_Frame_Done) begin
        check("done_expected", exp_done > 0, 1);
        if (exp_done > 0) exp_done--;
        check("done_after_writes", exp_wa.size(), 0);
        check("done_valid_low", o_Wr_Valid, 0);
      end
      if (o_Frame_Err) begin
        check("err_expected", exp_err.size() != 0, 1);
        if (exp_err.size() != 0) exp_code = exp_err.pop_front();
      end
      check("err_code", o_Err_Code, exp_code);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    model_byte(b);
    dv = 1'b1;
    rxb = b;
    tick();
    dv = 1'b0;
    tick();
  endtask

  task automatic send_last(input logic [7:0] b);
    model_byte(b);
    dv = 1'b1;
    rxb = b;
    tick();
    dv = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (!o_Busy && !o_Frame_Done && !o_Frame_Err) break;
      tick();
    end
    tick();
    check(nm, o_Busy, 0);
  endtask

  task automatic send_frame(input string nm);
    for (int i = 0; i < frm.size(); i++) send(frm[i]);
    wait_idle(nm);
  endtask

  task automatic scn_end(input string nm);
    check({nm, "_writes_left"}, exp_wa.size(), 0);
    check({nm, "_done_left"}, exp_done, 0);
    check({nm, "_err_left"}, exp_err.size(), 0);
  endtask

  task automatic good_frame(input string nm);
    frm = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
    send_frame(nm);
    scn_end(nm);
  endtask

  task automatic reset_now(input string nm);
    rst_n = 1'b0;
    dv = 1'b0;
    #1;
    check({nm, "_valid"}, o_Wr_Valid, 0);
    check({nm, "_busy"}, o_Busy, 0);
    check({nm, "_addr"}, o_Wr_Addr, 0);
    check({nm, "_data"}, o_Wr_Data, 0);
    check({nm, "_done"}, o_Frame_Done, 0);
    check({nm, "_err"}, o_Frame_Err, 0);
    check({nm, "_code"}, o_Err_Code, 0);
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic run_timeout(input string nm);
    int n;
    n = 0;
    model_timeout();
    while (!o_Frame_Err && n < 3 * T) begin
      tick();
      n++;
    end
    check({nm, "_latency"}, n, T - 1);
    check({nm, "_code"}, o_Err_Code, ERR_TIMEOUT);
    tick();
    check({nm, "_idle"}, o_Busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic seen;
    tick();
    check("reset_valid", o_Wr_Valid, 0);
    check("reset_busy", o_Busy, 0);
    check("reset_code", o_Err_Code, 0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("post_reset_busy", o_Busy, 0);
    started = 1'b1;

    // Good frame, cycle-exact
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22);
    send_last(8'h21);
    check("g_w0_valid", o_Wr_Valid, 1);
    check("g_w0_addr", o_Wr_Addr, 8'h10);
    check("g_w0_data", o_Wr_Data, 8'h11);
    tick();
    check("g_w1_addr", o_Wr_Addr, 8'h11);
    check("g_w1_data", o_Wr_Data, 8'h22);
    tick();
    check("g_valid_drop", o_Wr_Valid, 0);
    check("g_done", o_Frame_Done, 1);
    tick();
    check("g_done_pulse", o_Frame_Done, 0);
    check("g_code", o_Err_Code, ERR_NONE);
    wait_idle("g_idle");
    scn_end("good");

    // Address wrap
    send(8'hA5); send(8'hFF); send(8'h02); send(8'hAA); send(8'hBB);
    send_last(8'hEC);
    check("wrap_w0_addr", o_Wr_Addr, 8'hFF);
    check("wrap_w0_data", o_Wr_Data, 8'hAA);
    tick();
    check("wrap_w1_addr", o_Wr_Addr, 8'h00);
    check("wrap_w1_data", o_Wr_Data, 8'hBB);
    wait_idle("wrap_idle");
    scn_end("wrap");

    // Bad checksum, then good frame keeps the sticky code
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11); send(8'h22);
    send_last(8'h20);
    check("badchk_err", o_Frame_Err, 1);
    check("badchk_code", o_Err_Code, ERR_CHK);
    check("badchk_nowrite", o_Wr_Valid, 0);
    wait_idle("badchk_idle");
    scn_end("badchk");
    good_frame("after_badchk");
    check("sticky_chk", o_Err_Code, ERR_CHK);

    // Bad length
    send(8'hA5); send(8'h00);
    send_last(8'h11);
    check("badlen_err", o_Frame_Err, 1);
    check("badlen_code", o_Err_Code, ERR_LEN);
    wait_idle("badlen_idle");
    scn_end("badlen");
    good_frame("after_badlen");

    // Zero-length frame and non-SYNC noise in idle
    send(8'h3C);
    send(8'hA5); send(8'h30); send(8'h00);
    send_last(8'h30);
    check("zlen_done", o_Frame_Done, 1);
    check("zlen_nowrite", o_Wr_Valid, 0);
    wait_idle("zlen_idle");
    scn_end("zlen");

    // Timeout after ADDR
    send(8'hA5);
    model_byte(8'h10);
    dv = 1'b1; rxb = 8'h10; tick(); dv = 1'b0;
    run_timeout("to");
    scn_end("to");
    good_frame("after_to");

    // Byte on the limit cycle restarts the count
    send(8'hA5);
    model_byte(8'h10);
    dv = 1'b1; rxb = 8'h10; tick(); dv = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < T - 2; i++) begin
      tick();
      seen = seen | o_Frame_Err;
    end
    model_byte(8'h00);
    dv = 1'b1; rxb = 8'h00; tick(); dv = 1'b0;
    seen = seen | o_Frame_Err;
    check("restart_no_err", seen, 0);
    check("restart_busy", o_Busy, 1);
    run_timeout("to2");
    scn_end("to2");
    good_frame("after_to2");

    // Backpressure with an ignored SYNC during drain
    send(8'hA5); send(8'h20); send(8'h03); send(8'h01); send(8'h02); send(8'h03);
    rdy = 1'b0;
    send_last(8'h23);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", o_Wr_Valid, 1);
      check("bp_addr", o_Wr_Addr, 8'h20);
      check("bp_data", o_Wr_Data, 8'h01);
      if (i == 2) begin
        model_byte(8'hA5);
        dv = 1'b1; rxb = 8'hA5; tick(); dv = 1'b0;
        check("bp_busy", o_Busy, 1);
      end else begin
        tick();
      end
    end
    rdy = 1'b1;
    wait_idle("bp_idle");
    scn_end("bp");
    good_frame("after_bp");

    // Reset mid-payload
    send(8'hA5); send(8'h40); send(8'h04); send(8'h01); send(8'h02);
    check("midpay_busy", o_Busy, 1);
    reset_now("rst_pay");
    good_frame("after_rst_pay");

    // Reset mid-drain, after the first of two writes
    send(8'hA5); send(8'h50); send(8'h02); send(8'h01); send(8'h02);
    send_last(8'h51);
    tick();
    check("middrain_valid", o_Wr_Valid, 1);
    check("middrain_addr", o_Wr_Addr, 8'h51);
    #2;
    reset_now("rst_drain");
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_Wr_Valid) n++;
    end
    check("rst_drain_nowrite", n, 0);
    good_frame("after_rst_drain");
    check("final_code", o_Err_Code, ERR_NONE);

    started = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
Name: uart_frame_ctrl

Overview:
- Sits directly downstream of uart_rx; consumes its one-cycle byte-valid pulses and byte bus.
- Parses framed commands: SYNC, ADDR, LEN, PAYLOAD[LEN], CHK.
- Buffers the payload. Only after the checksum passes does it drain the payload as byte writes to a register-file write port, using a valid/ready handshake.
- Reports frame completion and errors (bad length, bad checksum, inter-byte timeout) as pulses plus a sticky error code.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- MAX_LEN, 16, maximum payload bytes; buffer depth.
- TIMEOUT_CLKS, 86800, idle clocks allowed between bytes inside a frame (10 byte times at 868 clks/bit).

Ports:
- i_Clock  in  1  system clock.
- i_nRst  in  1  asynchronous, active-low reset.
- i_Rx_DV  in  1  byte-valid pulse from the UART receiver.
- i_Rx_Byte  in  8  received byte; valid when i_Rx_DV=1.
- i_Wr_Ready  in  1  register file accepts a write this cycle.
- o_Wr_Valid  out  1  write request.
- o_Wr_Addr  out  8  write address.
- o_Wr_Data  out  8  write data.
- o_Busy  out  1  high in every state except IDLE.
- o_Frame_Done  out  1  one-cycle pulse: frame fully written.
- o_Frame_Err  out  1  one-cycle pulse: frame aborted.
- o_Err_Code  out  2  last error: 00 none, 01 bad LEN, 10 bad CHK, 11 timeout.

Behaviour:
- Reset (async assert, sync deassert in the clock domain):
  - All outputs 0, state IDLE, counters and checksum cleared.
  - Buffer contents are don't-care.
  - Reset mid-frame or mid-drain abandons the frame; no further writes.
- States: IDLE, ADDR, LEN, PAYLOAD, CHK, DRAIN. Transitions occur only on cycles with i_Rx_DV=1, except DRAIN and the timeout path.
- IDLE: on DV with byte==SYNC_BYTE -> ADDR. Any other byte is ignored.
- ADDR: on DV, base_addr<=byte, chk<=byte -> LEN.
- LEN:
  - byte>MAX_LEN -> error 01, -> IDLE.
  - byte==0 -> CHK.
  - otherwise len<=byte, idx<=0 -> PAYLOAD.
  - In every case chk^=byte.
- PAYLOAD: on each DV, buf[idx]<=byte, chk^=byte, idx++. When idx reaches len-1 with DV -> CHK.
- CHK: on DV compare byte with the running XOR (ADDR^LEN^payload bytes).
  - Mismatch -> error 10, -> IDLE. Nothing is written.
  - Match with len==0 -> o_Frame_Done next cycle, -> IDLE.
  - Match with len>0 -> idx<=0, -> DRAIN.
- DRAIN:
  - o_Wr_Valid=1, o_Wr_Addr=base_addr+idx (8-bit, wraps 0xFF->0x00), o_Wr_Data=buf[idx].
  - Outputs are registered and held stable while i_Wr_Ready=0.
  - Each Valid&Ready advances idx. After the final transfer, o_Wr_Valid drops the next cycle, o_Frame_Done pulses that same cycle, -> IDLE.
  - i_Rx_DV during DRAIN is ignored, including SYNC bytes. Upstream uses o_Busy to pace.
- Timeout:
  - Counter runs in ADDR, LEN, PAYLOAD and CHK; it is cleared on every DV and on state entry.
  - When it reaches TIMEOUT_CLKS-1 with no DV -> error 11, -> IDLE.
  - If DV and timeout coincide, the DV wins.
  - Counter is inactive in IDLE and DRAIN.
- Error reporting:
  - o_Frame_Err pulses the cycle after the offending DV or timeout.
  - o_Err_Code updates in that same cycle and holds until the next error or reset. It is not cleared by a good frame.
- Width: timeout counter is $clog2(TIMEOUT_CLKS) bits; idx and len are $clog2(MAX_LEN+1) bits.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams;
  - error code constants ERR_NONE/ERR_LEN/ERR_CHK/ERR_TIMEOUT;
  - default SYNC_BYTE;
  - CLKS_PER_BIT default 868, shared with the receiver.
- One sub-module, uart_frame_buf: MAX_LEN x 8 register array with one synchronous write port and one combinational read port, indexed by idx.

Test Plan:
- Good frame: bytes A5 10 02 11 22 21, Ready=1 -> writes (0x10,0x11) then (0x11,0x22) on consecutive cycles, o_Frame_Done one pulse, o_Err_Code stays 00.
- Address wrap: A5 FF 02 AA BB EC -> writes (0xFF,0xAA), (0x00,0xBB), Frame_Done.
- Bad checksum / bad length:
  - A5 10 02 11 22 20 -> o_Frame_Err, code 10, zero writes.
  - A5 00 11 -> code 01 immediately after the LEN byte.
  - Each case is followed by a good frame that completes normally.
- Timeout: A5 10, then silence -> Frame_Err with code 11 exactly TIMEOUT_CLKS-1 clocks after the 0x10 DV. A byte arriving 1 clock before the limit restarts the count.
- Backpressure and drain: during DRAIN of the good frame, hold Ready low 5 cycles -> Valid, addr and data stable. Inject DV 0xA5 during DRAIN -> ignored, o_Busy=1.
- Reset mid-PAYLOAD and mid-DRAIN: assert i_nRst=0 asynchronously -> outputs 0 without waiting for a clock edge, no further writes, next frame parses correctly.
